led_blink_arbiter: RTL and testbench

Round-robin scheduler that shares the single board LED between up to N_REQ blink requesters. It sits between the Blinker logic and the LEDG output in the system1000 clock domain, downstream of the PLL and the reset synchroniser. Each granted requester gets a burst of a requested number of on/off blinks, timed by an internal tick prescaler. Completion is signalled back with a one-cycle done pulse.

---
 rtl/led_blink_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_led_blink_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// Round-robin owner of the board LED: each grant plays a burst of on/off blinks, then pulses done.
// Optional LED_BLINK_ABORT_EN: a granted requester dropping req mid-burst returns the arbiter to IDLE.
module led_blink_arbiter #(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 8,
    parameter int TICK_DIV  = 1000,
    parameter int ON_TICKS  = 250,
    parameter int OFF_TICKS = 250
) (
    input  logic                   system1000,
    input  logic                   system1000_rstn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_count,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   led
);

    localparam int PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TCK_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TCK_W-1:0] ON_LAST  = TCK_W'(ON_TICKS - 1);
    localparam logic [TCK_W-1:0] OFF_LAST = TCK_W'(OFF_TICKS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   remaining;
    logic [PRE_W-1:0]   pre;
    logic [TCK_W-1:0]   tick;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [CNT_W-1:0]   win_count;
    logic               pre_wrap;
    logic               on_end;
    logic               off_end;

    // First set request at or above the pointer, wrapping around.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    assign win_count = req_count[win*CNT_W +: CNT_W];
    assign pre_wrap  = (pre == PRE_LAST);
    assign on_end    = pre_wrap && (tick == ON_LAST);
    assign off_end   = pre_wrap && (tick == OFF_LAST);

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            pre       <= '0;
            tick      <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            led       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (found) begin
                        grant     <= N_REQ'(1) << win;
                        busy      <= 1'b1;
                        remaining <= win_count;
                        ptr       <= (win == PTR_LAST) ? '0 : win + 1'b1;
                        pre       <= '0;
                        tick      <= '0;
                        if (win_count != '0) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state <= DONE;
                            led   <= 1'b0;
                        end
                    end
                end

                ON: begin
`ifdef LED_BLINK_ABORT_EN
                    if ((req & grant) == '0) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        led   <= 1'b0;
                        pre   <= '0;
                        tick  <= '0;
                    end else
`endif
                    if (on_end) begin
                        state <= OFF;
                        led   <= 1'b0;
                        pre   <= '0;
                        tick  <= '0;
                    end else if (pre_wrap) begin
                        pre  <= '0;
                        tick <= tick + 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end

                OFF: begin
`ifdef LED_BLINK_ABORT_EN
                    if ((req & grant) == '0) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        led   <= 1'b0;
                        pre   <= '0;
                        tick  <= '0;
                    end else
`endif
                    if (off_end) begin
                        pre  <= '0;
                        tick <= '0;
                        if (remaining != '0) begin
                            remaining <= remaining - 1'b1;
                        end
                        // Last blink just finished: present done on entry to DONE.
                        if (remaining <= CNT_W'(1)) begin
                            state <= DONE;
                            done  <= grant;
                        end else begin
                            state <= ON;
                            led   <= 1'b1;
                        end
                    end else if (pre_wrap) begin
                        pre  <= '0;
                        tick <= tick + 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end

                DONE: begin
                    led <= 1'b0;
                    // A zero-count grant arrives here without done raised; raise it for one cycle first.
                    if (done == '0) begin
                        done <= grant;
                    end else begin
                        done  <= '0;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    led   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Scoreboard bench: stimulus queues timestamped output changes, a negedge monitor compares each change.
module tb_led_blink_arbiter;

    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int ONC = 8;   // ON_TICKS*TICK_DIV
    localparam int PER = 12;  // (ON_TICKS+OFF_TICKS)*TICK_DIV

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] req_count = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic            led;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int b;

    typedef struct {
        int         c;
        logic [3:0] g;
        logic [3:0] d;
        logic       l;
    } ev_t;

    ev_t exp_q[$];
    logic [8:0] prev = '0;

    led_blink_arbiter #(
        .N_REQ(N), .CNT_W(CW), .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1)
    ) dut (
        .system1000(clk),
        .system1000_rstn(rstn),
        .req(req),
        .req_count(req_count),
        .grant(grant),
        .done(done),
        .busy(busy),
        .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int c, logic [3:0] g, logic [3:0] d, logic l);
        ev_t e;
        e.c = c; e.g = g; e.d = d; e.l = l;
        exp_q.push_back(e);
    endfunction

    function automatic void burst(int base, logic [3:0] g, int cnt);
        if (cnt == 0) begin
            push(base, g, 4'b0, 1'b0);
            push(base + 1, g, g, 1'b0);
            push(base + 2, 4'b0, 4'b0, 1'b0);
        end else begin
            push(base, g, 4'b0, 1'b1);
            for (int k = 0; k < cnt; k++) begin
                push(base + PER*k + ONC, g, 4'b0, 1'b0);
                if (k < cnt - 1) push(base + PER*k + PER, g, 4'b0, 1'b1);
            end
            push(base + PER*cnt, g, g, 1'b0);
            push(base + PER*cnt + 1, 4'b0, 4'b0, 1'b0);
        end
    endfunction

    task automatic at_cycle(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_cnt(int i, logic [CW-1:0] v);
        req_count[i*CW +: CW] = v;
    endtask

    // Monitor: every change of the observable outputs must match the next queued event.
    always @(negedge clk) begin
        logic [8:0] now;
        ev_t e;
        now = {grant, done, led};
        if (now != prev) begin
            prev = now;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_change cyc=%0d got grant=%b done=%b led=%b busy=%b, required no change",
                         cyc, grant, done, led, busy);
            end else begin
                e = exp_q.pop_front();
                if (e.c != cyc || e.g != grant || e.d != done || e.l != led || busy != (e.g != 4'b0)) begin
                    $display("FAIL event cyc=%0d got grant=%b done=%b led=%b busy=%b, required cyc=%0d grant=%b done=%b led=%b busy=%b",
                             cyc, grant, done, led, busy, e.c, e.g, e.d, e.l, (e.g != 4'b0));
                end else begin
                    passed++;
                end
            end
        end
    end

    initial begin
        at_cycle(2);
        checks++;
        if (grant != 0 || done != 0 || busy != 0 || led != 0) begin
            $display("FAIL reset_state got grant=%b done=%b busy=%b led=%b, required all zero", grant, done, busy, led);
        end else begin
            passed++;
        end
        rstn = 1'b1;

        // Simultaneous requests, count 1 each: RR order 0,1,3,0.
        at_cycle(5);
        for (int i = 0; i < N; i++) set_cnt(i, 8'd1);
        req = 4'b1011;
        b = cyc + 1;
        burst(b, 4'b0001, 1);
        burst(b + 14, 4'b0010, 1);
        burst(b + 28, 4'b1000, 1);
        burst(b + 42, 4'b0001, 1);
        at_cycle(b + 43);
        req = 4'b0000;

        // Single requester 1, count 3.
        at_cycle(b + 60);
        set_cnt(1, 8'd3);
        req = 4'b0010;
        b = cyc + 1;
        burst(b, 4'b0010, 3);
        at_cycle(b + 36);
        req = 4'b0000;

        // Zero count on requester 2.
        at_cycle(b + 45);
        set_cnt(2, 8'd0);
        req = 4'b0100;
        b = cyc + 1;
        burst(b, 4'b0100, 0);
        at_cycle(b);
        req = 4'b0000;

        // Reset mid-burst; pointer must return to 0 afterwards.
        at_cycle(b + 10);
        set_cnt(1, 8'd3);
        req = 4'b0010;
        b = cyc + 1;
        push(b, 4'b0010, 4'b0, 1'b1);
        push(b + 5, 4'b0, 4'b0, 1'b0);
        at_cycle(b + 4);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        req = 4'b0000;
        at_cycle(b + 7);
        rstn = 1'b1;
        at_cycle(b + 12);
        set_cnt(1, 8'd0);
        set_cnt(3, 8'd0);
        req = 4'b1010;
        b = cyc + 1;
        burst(b, 4'b0010, 0);
        burst(b + 3, 4'b1000, 0);
        at_cycle(b + 3);
        req = 4'b0000;

        // Requester 1 drops req mid-burst while requester 2 waits.
        at_cycle(b + 10);
        set_cnt(1, 8'd3);
        set_cnt(2, 8'd0);
        req = 4'b0010;
        b = cyc + 1;
`ifdef LED_BLINK_ABORT_EN
        push(b, 4'b0010, 4'b0, 1'b1);
        push(b + 8, 4'b0010, 4'b0, 1'b0);
        push(b + 11, 4'b0, 4'b0, 1'b0);
        burst(b + 12, 4'b0100, 0);
        at_cycle(b + 2);
        req = 4'b0110;
        at_cycle(b + 10);
        req = 4'b0100;
        at_cycle(b + 12);
        req = 4'b0000;
`else
        burst(b, 4'b0010, 3);
        burst(b + 38, 4'b0100, 0);
        at_cycle(b + 2);
        req = 4'b0110;
        at_cycle(b + 10);
        req = 4'b0100;
        at_cycle(b + 38);
        req = 4'b0000;
`endif

        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain got %0d events still pending at cyc=%0d, required 0", exp_q.size(), cyc);
        end
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
